// File: rtl/shift_row_mix_stage_if.sv
// Purpose: beat-level bus for the encrypt round tail (input beat + key, output round result).
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
//
// Signals:
//   in_valid/in_ready   input handshake
//   in_state[127:0]     column-major state, [127:120]=a00 .. [7:0]=a33
//   in_key[127:0]       round key, same byte layout
//   in_last             final round flag (skip MixColumns)
//   out_valid/out_ready output handshake
//   out_state[127:0]    round result
//   out_last            in_last carried with the beat
// Modports: master = beat producer / result consumer, slave = the stage itself.
interface shift_row_mix_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_last;

    modport master (
        output in_valid,
        output in_state,
        output in_key,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  in_key,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state,
        output out_last
    );
endinterface

// File: rtl/shift_row_mix_stage.sv
// Purpose: AES forward round tail, ShiftRows -> MixColumns (skipped on in_last) -> AddRoundKey.
// Latency: 1 cycle from input transfer to out_* when the main register is free or draining.
// Backpressure: SKID=1 main+skid buffer with registered in_ready; SKID=0 single register,
//               in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   bus (slave)         in_valid/in_ready/in_state/in_key/in_last,
//                       out_valid/out_ready/out_state/out_last
//   blk_cnt[15:0]       output transfer counter, only when SHIFT_ROW_MIX_CNT_EN is defined
// Optional feature macro: SHIFT_ROW_MIX_CNT_EN (undefined: counter and port absent).
module shift_row_mix_stage #(
    parameter bit SKID = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_row_mix_stage_if.slave bus
`ifdef SHIFT_ROW_MIX_CNT_EN
    ,
    output logic [15:0]          blk_cnt
`endif
);

    // Buffer occupancy: EMPTY = nothing held, ONE = main register valid,
    // FULL = main and skid both valid (SKID=1 only).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic         last;
        logic [127:0] state;
    } beat_t;

    // GF(2^8) doubling with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // ------------------------------------------------------------------
    // Round datapath (combinational, ahead of the register)
    // ------------------------------------------------------------------
    // Byte arrays are indexed 4*col+row, matching the column-major bus layout.
    logic [7:0]   st_b [16];
    logic [7:0]   sh_b [16];
    logic [7:0]   mx_b [16];
    logic [127:0] res_state;
    beat_t        new_beat;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            st_b[i] = bus.in_state[127-8*i -: 8];
        end

        // Row r rotates left by r: output column c, row r takes input column (c+r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sh_b[4*c+r] = st_b[4*((c+r)%4)+r];
            end
        end

        for (int c = 0; c < 4; c++) begin
            mx_b[4*c+0] = xtime(sh_b[4*c+0]) ^ mul3(sh_b[4*c+1]) ^ sh_b[4*c+2] ^ sh_b[4*c+3];
            mx_b[4*c+1] = sh_b[4*c+0] ^ xtime(sh_b[4*c+1]) ^ mul3(sh_b[4*c+2]) ^ sh_b[4*c+3];
            mx_b[4*c+2] = sh_b[4*c+0] ^ sh_b[4*c+1] ^ xtime(sh_b[4*c+2]) ^ mul3(sh_b[4*c+3]);
            mx_b[4*c+3] = mul3(sh_b[4*c+0]) ^ sh_b[4*c+1] ^ sh_b[4*c+2] ^ xtime(sh_b[4*c+3]);
        end

        res_state = '0;
        for (int i = 0; i < 16; i++) begin
            res_state[127-8*i -: 8] = (bus.in_last ? sh_b[i] : mx_b[i]) ^ bus.in_key[127-8*i -: 8];
        end

        new_beat.last  = bus.in_last;
        new_beat.state = res_state;
    end

    // ------------------------------------------------------------------
    // Handshake / buffer control
    // ------------------------------------------------------------------
    logic [1:0] occ_q, occ_d;
    beat_t      m_q, m_d;
    beat_t      s_q, s_d;
    logic       in_rdy_q, in_rdy_d;
    logic       in_xfer;
    logic       out_xfer;

    assign bus.out_valid = (occ_q != ST_EMPTY);
    assign bus.out_state = m_q.state;
    assign bus.out_last  = m_q.last;
    assign bus.in_ready  = SKID ? in_rdy_q : ((occ_q == ST_EMPTY) | bus.out_ready);

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = (occ_q != ST_EMPTY) & bus.out_ready;

    always_comb begin
        occ_d = occ_q;
        m_d   = m_q;
        s_d   = s_q;

        if (SKID) begin
            case (occ_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        m_d   = new_beat;
                        occ_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_d = new_beat;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the new beat behind the main register.
                        s_d   = new_beat;
                        occ_d = ST_FULL;
                    end else if (out_xfer) begin
                        occ_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_xfer) begin
                        m_d   = s_q;
                        occ_d = ST_ONE;
                    end
                end
                default: begin
                    occ_d = ST_EMPTY;
                end
            endcase
        end else begin
            if (in_xfer) begin
                m_d   = new_beat;
                occ_d = ST_ONE;
            end else if (out_xfer) begin
                occ_d = ST_EMPTY;
            end
        end

        // Registered ready: next-cycle acceptance is decided from next-cycle occupancy.
        in_rdy_d = (occ_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q    <= ST_EMPTY;
            m_q      <= '0;
            s_q      <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            occ_q    <= occ_d;
            m_q      <= m_d;
            s_q      <= s_d;
            in_rdy_q <= in_rdy_d;
        end
    end

`ifdef SHIFT_ROW_MIX_CNT_EN
    // Output transfer counter, wraps naturally at 16 bits.
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (out_xfer) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= 16'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_shift_row_mix_stage.sv
// Purpose: self-checking bench for shift_row_mix_stage (SKID=1) against a byte-level AES model.
// Latency: checks the one-cycle accept-to-output path and full-rate streaming.
// Backpressure: exercises stall, skid fill, hold-stable outputs and reset with a full buffer.
module tb_shift_row_mix_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_row_mix_stage_if ifc ();

`ifdef SHIFT_ROW_MIX_CNT_EN
    logic [15:0] blk_cnt;
`endif

    shift_row_mix_stage #(.SKID(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
`ifdef SHIFT_ROW_MIX_CNT_EN
        ,
        .blk_cnt (blk_cnt)
`endif
    );

    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    int            fail_cnt = 0;
    logic [128:0]  sb_q [$];
    logic [15:0]   exp_cnt;
    logic          hold_vld;
    logic [129:0]  hold_dat;

    // ---------------- reference model ----------------
    // General GF(2^8) product by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    // Returns {last, round_result}.
    function automatic logic [128:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
        logic [7:0]   a    [16];
        logic [7:0]   sh   [16];
        logic [7:0]   mx   [16];
        logic [7:0]   coef [4];
        logic [127:0] r;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r    = '0;
        for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                sh[4*c+rr] = a[4*((c+rr)%4)+rr];
        // MixColumns as a circulant matrix product, row rr = coef rotated right by rr.
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
                mx[4*c+rr] = 8'h00;
                for (int k = 0; k < 4; k++)
                    mx[4*c+rr] = mx[4*c+rr] ^ gmul(coef[(k-rr+4)%4], sh[4*c+k]);
            end
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = (last ? sh[i] : mx[i]) ^ key[127-8*i -: 8];
        return {last, r};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef SHIFT_ROW_MIX_CNT_EN
        check(tag, blk_cnt, exp);
`endif
    endtask

    // One clock: at the falling edge score the transfers that the next rising edge
    // will perform, then return 1 time unit after that rising edge.
    task automatic tick();
        logic [128:0] e;
        @(negedge clk);
        if (hold_vld) check("hold_stable", {ifc.out_valid, ifc.out_last, ifc.out_state}, hold_dat);
        if (ifc.out_valid && ifc.out_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", ifc.out_valid, 0);
            end else begin
                e = sb_q.pop_front();
                check("out_state", ifc.out_state, e[127:0]);
                check("out_last", ifc.out_last, e[128]);
            end
            exp_cnt = exp_cnt + 16'd1;
        end
        hold_vld = ifc.out_valid && !ifc.out_ready;
        hold_dat = {ifc.out_valid, ifc.out_last, ifc.out_state};
        if (ifc.in_valid && ifc.in_ready)
            sb_q.push_back(ref_round(ifc.in_state, ifc.in_key, ifc.in_last));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifc.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_state", ifc.out_state, 0);
        check("rst_out_last", ifc.out_last, 0);
        check("rst_in_ready", ifc.in_ready, 1);
        check_cnt("rst_blk_cnt", 16'd0);
        sb_q.delete();
        exp_cnt  = 16'd0;
        hold_vld = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [127:0] st, input logic [127:0] key, input logic last);
        ifc.in_valid = 1'b1;
        ifc.in_state = st;
        ifc.in_key   = key;
        ifc.in_last  = last;
    endtask

    task automatic one_beat(input string tag, input logic [127:0] st, input logic [127:0] key,
                            input logic last, input logic [127:0] exp_st);
        drive(st, key, last);
        ifc.out_ready = 1'b1;
        tick();
        check({tag, "_valid"}, ifc.out_valid, 1);
        check({tag, "_state"}, ifc.out_state, exp_st);
        check({tag, "_last"}, ifc.out_last, last);
        ifc.in_valid = 1'b0;
        tick();
        check({tag, "_drained"}, ifc.out_valid, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] k;
        int           stall;
        int           guard;

        ifc.in_valid  = 1'b0;
        ifc.in_state  = '0;
        ifc.in_key    = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b0;
        exp_cnt       = 16'd0;
        hold_vld      = 1'b0;
        hold_dat      = '0;
        rst           = 1'b1;

        do_reset();

        // FIPS-197 Appendix B, round 1
        one_beat("fips_r1", 128'hd42711aee0bf98f1b8b45de51e415230,
                 128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
                 128'ha49c7ff2689f352b6b5bea43026a5049);
        // ShiftRows only
        one_beat("shift_only", 128'h000102030405060708090a0b0c0d0e0f, 128'h0, 1'b1,
                 128'h00050a0f04090e03080d02070c01060b);
        // Zero state: result is the key whether or not MixColumns runs
        k = rand128();
        one_beat("key_mix", 128'h0, k, 1'b0, k);
        one_beat("key_last", 128'h0, k, 1'b1, k);

        // Backpressure: fill main and skid, then drain in order
        ifc.out_ready = 1'b0;
        drive(rand128(), rand128(), 1'b0);
        tick();
        check("bp_rdy_after_1", ifc.in_ready, 1);
        drive(rand128(), rand128(), 1'b1);
        tick();
        check("bp_rdy_after_2", ifc.in_ready, 0);
        check("bp_valid_full", ifc.out_valid, 1);
        drive(rand128(), rand128(), 1'b0);   // offered while full, must be refused
        tick();
        check("bp_rdy_still_full", ifc.in_ready, 0);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        check("bp_rdy_after_pop", ifc.in_ready, 1);
        check("bp_valid_second", ifc.out_valid, 1);
        tick();
        check("bp_empty", ifc.out_valid, 0);
        check("bp_sb_empty", sb_q.size(), 0);

        // Random valid/ready traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) drive(rand128(), rand128(), 1'($urandom_range(0, 1)));
            else ifc.in_valid = 1'b0;
            ifc.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 10) begin
            tick();
            guard++;
        end
        check("rand_drain", sb_q.size(), 0);
        tick();
        check("rand_idle", ifc.out_valid, 0);
        check_cnt("rand_blk_cnt", exp_cnt);

        // Full-rate streaming from a clean reset
        do_reset();
        ifc.out_ready = 1'b1;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            drive(rand128(), rand128(), 1'($urandom_range(0, 1)));
            tick();
            if (!ifc.out_valid || !ifc.in_ready) stall++;
        end
        ifc.in_valid = 1'b0;
        tick();
        check("stream_stalls", stall, 0);
        check("stream_outputs", exp_cnt, 100);
        check("stream_sb_empty", sb_q.size(), 0);
        check_cnt("stream_blk_cnt", 16'd100);

        // Reset while full
        ifc.out_ready = 1'b0;
        drive(rand128(), rand128(), 1'b0);
        tick();
        drive(rand128(), rand128(), 1'b1);
        tick();
        check("full_before_rst", ifc.in_ready, 0);
        do_reset();
        check("post_rst_idle", ifc.out_valid, 0);
        k = rand128();
        drive(k, rand128(), 1'b0);
        ifc.out_ready = 1'b1;
        tick();
        check("post_rst_valid", ifc.out_valid, 1);
        ifc.in_valid = 1'b0;
        tick();
        check("post_rst_drained", ifc.out_valid, 0);
        check_cnt("post_rst_blk_cnt", 16'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
